// File: rtl/jtdsp16_pkg.sv
// rtl/jtdsp16_pkg.sv - shared constants for the DSP16 do/redo loop cache
package jtdsp16_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int DO_NI_MAX = 15;

  // do_data layout: [10:7] = NI, [6:0] = K
  localparam int DO_NI_MSB = 10;
  localparam int DO_NI_LSB = 7;
  localparam int DO_K_MSB  = 6;
  localparam int DO_K_LSB  = 0;

endpackage

// File: rtl/jtdsp16_cache_ram.sv
// rtl/jtdsp16_cache_ram.sv - DEPTHx16 register file, sync write, async read, async clear
module jtdsp16_cache_ram #(
  parameter int DEPTH = 15,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout
);

  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we && ({1'b0, waddr} < LIM)) begin
      r_mem[waddr] <= din;
    end
  end

  assign dout = ({1'b0, raddr} < LIM) ? r_mem[raddr] : '0;

endmodule

// File: rtl/jtdsp16_do_cache.sv
// rtl/jtdsp16_do_cache.sv - do/redo loop sequencer: captures NI words from ROM, replays them K times
module jtdsp16_do_cache
  import jtdsp16_pkg::*;
#(
  parameter int DEPTH = DO_NI_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        fetch,
  input  logic        do_start,
  input  logic [10:0] do_data,
  input  logic [15:0] rom_dout,
  output logic [15:0] cache_dout,
  output logic        cache_sel,
  output logic        pc_hold,
  output logic        busy,
  output logic [6:0]  loop_cnt,
  output logic        fault
);

  logic [1:0] r_state;
  logic [3:0] r_ni;
  logic [3:0] r_idx;
  logic [6:0] r_cnt;
  logic       r_fault;

  logic [3:0] w_ni;
  logic [6:0] w_k;
  logic       w_last;
  logic       w_we;

  assign w_ni   = do_data[DO_NI_MSB:DO_NI_LSB];
  assign w_k    = do_data[DO_K_MSB:DO_K_LSB];
  assign w_last = (r_idx == r_ni - 4'd1);
  assign w_we   = cen && fetch && (r_state == ST_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ni    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else if (cen) begin
      r_fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (do_start) begin
            if (w_ni != 4'd0) begin
              r_ni    <= w_ni;
              r_idx   <= '0;
              // K<=1 still caches the body but leaves nothing to replay
              r_cnt   <= (w_k >= 7'd2) ? w_k - 7'd1 : 7'd0;
              r_state <= ST_LOAD;
            end else if (w_k != 7'd0) begin
              if (r_ni != 4'd0) begin
                r_idx   <= '0;
                r_cnt   <= w_k;
                r_state <= ST_RUN;
              end else begin
                r_fault <= 1'b1;
              end
            end
          end
        end
        ST_LOAD: begin
          if (do_start) r_fault <= 1'b1;
          if (fetch) begin
            if (w_last) begin
              r_idx   <= '0;
              r_state <= (r_cnt != 7'd0) ? ST_RUN : ST_IDLE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        ST_RUN: begin
          if (do_start) r_fault <= 1'b1;
          if (fetch) begin
            if (w_last) begin
              r_idx <= '0;
              r_cnt <= r_cnt - 7'd1;
              if (r_cnt == 7'd1) r_state <= ST_IDLE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  jtdsp16_cache_ram #(
    .DEPTH (DEPTH),
    .AW    (4),
    .DW    (16)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (r_idx),
    .din   (rom_dout),
    .raddr (r_idx),
    .dout  (cache_dout)
  );

  assign cache_sel = (r_state == ST_RUN);
  assign pc_hold   = (r_state == ST_RUN);
  assign busy      = (r_state != ST_IDLE);
  assign loop_cnt  = r_cnt;
  assign fault     = r_fault;

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// tb/tb_jtdsp16_do_cache.sv - scoreboard bench for jtdsp16_do_cache
module tb_jtdsp16_do_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        fetch = 1'b0;
  logic        do_start = 1'b0;
  logic [10:0] do_data = '0;
  logic [15:0] rom_dout = '0;
  logic [15:0] cache_dout;
  logic        cache_sel;
  logic        pc_hold;
  logic        busy;
  logic [6:0]  loop_cnt;
  logic        fault;

  typedef struct {
    logic [15:0] w;
    logic [6:0]  c;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  jtdsp16_do_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .fetch      (fetch),
    .do_start   (do_start),
    .do_data    (do_data),
    .rom_dout   (rom_dout),
    .cache_dout (cache_dout),
    .cache_sel  (cache_sel),
    .pc_hold    (pc_hold),
    .busy       (busy),
    .loop_cnt   (loop_cnt),
    .fault      (fault)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] ni, input logic [6:0] k);
    cen = 1'b1; fetch = 1'b0; do_start = 1'b1; do_data = {ni, k};
    step();
    do_start = 1'b0; do_data = '0;
  endtask

  task automatic idle();
    cen = 1'b1; fetch = 1'b0; do_start = 1'b0;
    step();
  endtask

  task automatic fetch_rom(input logic [15:0] w);
    cen = 1'b1; fetch = 1'b1; rom_dout = w;
    step();
    fetch = 1'b0;
  endtask

  task automatic fetch_cache(input logic [15:0] w, input logic [6:0] c);
    exp_t e;
    e.w = w; e.c = c;
    q.push_back(e);
    cen = 1'b1; fetch = 1'b1; rom_dout = 16'hDEAD;
    step();
    fetch = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    check({nm, " busy"}, busy, 0);
    check({nm, " cache_sel"}, cache_sel, 0);
    check({nm, " pc_hold"}, pc_hold, 0);
  endtask

  task automatic drive();
    logic [15:0] body [3];
    body[0] = 16'hA0A0; body[1] = 16'hB1B1; body[2] = 16'hC2C2;

    // reset state
    #2;
    check_idle("reset");
    check("reset fault", fault, 0);
    check("reset loop_cnt", loop_cnt, 0);
    step();
    rst_n = 1'b1;
    idle();

    // redo straight after reset must fault
    issue(4'd0, 7'd3);
    check("redo-after-reset fault", fault, 1);
    check("redo-after-reset busy", busy, 0);
    idle();
    check("fault one cen", fault, 0);

    // do NI=3 K=4 with stalls in the second pass
    issue(4'd3, 7'd4);
    check("do busy", busy, 1);
    check("do loop_cnt", loop_cnt, 3);
    for (int i = 0; i < 3; i++) fetch_rom(body[i]);
    for (int i = 0; i < 3; i++) fetch_cache(body[i], 7'd3);
    fetch_cache(body[0], 7'd2);
    idle();
    idle();
    cen = 1'b0; fetch = 1'b1; step(); fetch = 1'b0; cen = 1'b1;
    check("stall cache_dout", cache_dout, body[1]);
    check("stall loop_cnt", loop_cnt, 2);
    fetch_cache(body[1], 7'd2);
    fetch_cache(body[2], 7'd2);
    for (int i = 0; i < 3; i++) fetch_cache(body[i], 7'd1);
    check_idle("after do");
    check("after do loop_cnt", loop_cnt, 0);
    fetch_rom(16'h0001);

    // redo K=2
    issue(4'd0, 7'd2);
    check("redo cache_sel", cache_sel, 1);
    check("redo loop_cnt", loop_cnt, 2);
    for (int i = 0; i < 3; i++) fetch_cache(body[i], 7'd2);
    for (int i = 0; i < 3; i++) fetch_cache(body[i], 7'd1);
    check_idle("after redo");

    // nested do during RUN faults and is ignored
    issue(4'd0, 7'd1);
    fetch_cache(body[0], 7'd1);
    issue(4'd3, 7'd5);
    check("nested fault", fault, 1);
    check("nested busy", busy, 1);
    check("nested loop_cnt", loop_cnt, 1);
    check("nested cache_dout", cache_dout, body[1]);
    fetch_cache(body[1], 7'd1);
    fetch_cache(body[2], 7'd1);
    check_idle("after nested");

    // NI=2 K=1: capture only, then replay via redo; redo K=0 is a no-op
    issue(4'd2, 7'd1);
    fetch_rom(16'h1111);
    fetch_rom(16'h2222);
    check_idle("k1 load");
    issue(4'd0, 7'd0);
    check("redo k0 fault", fault, 0);
    check("redo k0 busy", busy, 0);
    issue(4'd0, 7'd1);
    fetch_cache(16'h1111, 7'd1);
    fetch_cache(16'h2222, 7'd1);
    check_idle("k1 redo");

    // NI=15 K=2
    issue(4'd15, 7'd2);
    for (int i = 0; i < 15; i++) fetch_rom(16'h1000 + 16'(i));
    for (int i = 0; i < 15; i++) fetch_cache(16'h1000 + 16'(i), 7'd1);
    check_idle("ni15");

    // NI=1 K=127
    issue(4'd1, 7'd127);
    fetch_rom(16'hBEEF);
    for (int i = 126; i >= 1; i--) fetch_cache(16'hBEEF, 7'(i));
    check_idle("k127");
    check("k127 loop_cnt", loop_cnt, 0);

    // reset mid-RUN
    issue(4'd0, 7'd3);
    fetch_cache(16'hBEEF, 7'd3);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async reset");
    check("async reset loop_cnt", loop_cnt, 0);
    check("async reset cache_dout", cache_dout, 0);
    step();
    rst_n = 1'b1;
    idle();
    issue(4'd0, 7'd2);
    check("redo after reset fault", fault, 1);
    check("redo after reset busy", busy, 0);
    idle();
    done = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (rst_n && cen && fetch && cache_sel) begin
        if (q.size() == 0) begin
          check("unexpected cache fetch", {16'h0, cache_dout}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("cache word", cache_dout, e.w);
          check("cache loop_cnt", loop_cnt, e.c);
          check("cache pc_hold", pc_hold, 1);
        end
      end
    end
  endtask

  initial begin
    fork
      drive();
      monitor();
    join
    check("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
